// File: rtl/popcount_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : popcount_frame_accumulator
// Purpose  : Streams VECTOR_SIZE-bit beats, popcounts each beat and sums the
//            counts over an in_last-delimited frame. Emits one saturating
//            per-frame total (count, beats, overflow) held until accepted.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Recursive tree popcount: split the vector in halves and add the sub-counts.
// ----------------------------------------------------------------------------
module popcount_frame_accumulator_pc #(
  parameter int W = 16
) (
  input  logic [W-1:0]      vec_i,
  output logic [$clog2(W):0] cnt_o
);

  generate
    if (W == 1) begin : g_leaf
      assign cnt_o = vec_i;
    end else begin : g_split
      localparam int H = W / 2;
      logic [$clog2(H):0] lo_cnt;
      logic [$clog2(H):0] hi_cnt;

      popcount_frame_accumulator_pc #(.W(H)) u_lo (
        .vec_i (vec_i[H-1:0]),
        .cnt_o (lo_cnt)
      );

      popcount_frame_accumulator_pc #(.W(W - H)) u_hi (
        .vec_i (vec_i[W-1:H]),
        .cnt_o (hi_cnt)
      );

      assign cnt_o = {1'b0, lo_cnt} + {1'b0, hi_cnt};
    end
  endgenerate

endmodule

// ----------------------------------------------------------------------------
// Frame accumulator top
// ----------------------------------------------------------------------------
module popcount_frame_accumulator #(
  parameter int VECTOR_SIZE = 16,
  parameter int ACC_WIDTH   = 16,
  parameter int BEAT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VECTOR_SIZE-1:0] in_vector,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_count,
  output logic [BEAT_WIDTH-1:0]  out_beats,
  output logic                   out_overflow
);

  localparam int PC_W = $clog2(VECTOR_SIZE) + 1;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                state_q;

  // Pipeline register between the popcount tree and the accumulators
  logic                  p_valid_q;
  logic [PC_W-1:0]       p_cnt_q;
  logic                  p_last_q;

  // Running frame totals
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [BEAT_WIDTH-1:0] beats_q;
  logic                  ovf_q;

  // Registered result
  logic                  out_valid_q;
  logic [ACC_WIDTH-1:0]  out_count_q;
  logic [BEAT_WIDTH-1:0] out_beats_q;
  logic                  out_overflow_q;

  logic [PC_W-1:0]       beat_cnt;
  logic                  in_fire;
  logic [ACC_WIDTH:0]    acc_sum;
  logic [BEAT_WIDTH:0]   beats_sum;
  logic [ACC_WIDTH-1:0]  acc_d;
  logic [BEAT_WIDTH-1:0] beats_d;
  logic                  ovf_d;

  popcount_frame_accumulator_pc #(.W(VECTOR_SIZE)) u_pc (
    .vec_i (in_vector),
    .cnt_o (beat_cnt)
  );

  // Ready is blocked while a last beat sits in P so the next frame cannot
  // enter before the current one has moved into the output register.
  assign in_ready = rst_n && (state_q == ACCUM) && !(p_valid_q && p_last_q);
  assign in_fire  = in_valid && in_ready;

  // Saturating next values: add one bit wider and clamp on carry-out.
  always_comb begin
    acc_sum   = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PC_W){1'b0}}, p_cnt_q};
    beats_sum = {1'b0, beats_q} + {{BEAT_WIDTH{1'b0}}, 1'b1};
    acc_d     = acc_sum[ACC_WIDTH]    ? {ACC_WIDTH{1'b1}}  : acc_sum[ACC_WIDTH-1:0];
    beats_d   = beats_sum[BEAT_WIDTH] ? {BEAT_WIDTH{1'b1}} : beats_sum[BEAT_WIDTH-1:0];
    ovf_d     = ovf_q | acc_sum[ACC_WIDTH] | beats_sum[BEAT_WIDTH];
  end

  // Capture each accepted beat's popcount into the pipeline register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_cnt_q   <= '0;
      p_last_q  <= 1'b0;
    end else begin
      p_valid_q <= in_fire;
      if (in_fire) begin
        p_cnt_q  <= beat_cnt;
        p_last_q <= in_last;
      end
    end
  end

  // Frame FSM: accumulate, publish on the last beat, hold until accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ACCUM;
      acc_q          <= '0;
      beats_q        <= '0;
      ovf_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_count_q    <= '0;
      out_beats_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (p_valid_q && p_last_q) begin
            out_count_q    <= acc_d;
            out_beats_q    <= beats_d;
            out_overflow_q <= ovf_d;
            out_valid_q    <= 1'b1;
            acc_q          <= '0;
            beats_q        <= '0;
            ovf_q          <= 1'b0;
            state_q        <= HOLD;
          end else if (p_valid_q) begin
            acc_q   <= acc_d;
            beats_q <= beats_d;
            ovf_q   <= ovf_d;
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_count    = out_count_q;
  assign out_beats    = out_beats_q;
  assign out_overflow = out_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_popcount_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_popcount_frame_accumulator
// Purpose  : Directed checks of the popcount frame accumulator (ACC_WIDTH=8
//            so saturation is reachable with short frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_popcount_frame_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vector;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_count;
  logic [15:0] out_beats;
  logic        out_overflow;

  int checks = 0;
  int errors = 0;

  popcount_frame_accumulator #(
    .VECTOR_SIZE (16),
    .ACC_WIDTH   (8),
    .BEAT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_vector    (in_vector),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_count    (out_count),
    .out_beats    (out_beats),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;

  // Advance one cycle; sample point is 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a beat and return 1 ns after the edge on which it was accepted.
  task automatic send_beat(input logic [15:0] vec, input logic last);
    int n;
    in_valid  = 1'b1;
    in_vector = vec;
    in_last   = last;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("accept_timeout", {31'd0, n < 50}, 32'd1);
    step();
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Wait (bounded) until out_valid is high.
  task automatic wait_out();
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("out_timeout", {31'd0, n < 50}, 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic [7:0] cnt,
                            input logic [15:0] bts, input logic ovf);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_count"}, {24'd0, out_count}, {24'd0, cnt});
    chk({tag, "_beats"}, {16'd0, out_beats}, {16'd0, bts});
    chk({tag, "_ovf"},   {31'd0, out_overflow}, {31'd0, ovf});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vector = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count",     {24'd0, out_count}, 32'd0);
    chk("rst_beats",     {16'd0, out_beats}, 32'd0);
    chk("rst_ovf",       {31'd0, out_overflow}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Single-beat frame: exact latency T+1 / T+2 / T+3
    send_beat(16'hFFFF, 1'b1);
    in_valid = 1'b0;
    chk("t1_ready_low",  {31'd0, in_ready}, 32'd0);
    chk("t1_not_valid",  {31'd0, out_valid}, 32'd0);
    step();
    chk_result("t1", 8'd16, 16'd1, 1'b0);
    chk("t1_ready_hold", {31'd0, in_ready}, 32'd0);
    step();
    chk("t1_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t1_ready_back", {31'd0, in_ready}, 32'd1);

    // 3-beat frame with a 2-cycle gap: 4 + 8 + 8
    send_beat(16'h000F, 1'b0);
    idle(2);
    send_beat(16'h00FF, 1'b0);
    send_beat(16'hF0F0, 1'b1);
    in_valid = 1'b0;
    wait_out();
    chk_result("t2", 8'd20, 16'd3, 1'b0);
    step();

    // Backpressure: result held for 10 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(16'h0001, i == 3);
    in_valid = 1'b0;
    wait_out();
    for (int i = 0; i < 10; i++) begin
      chk_result("t3_hold", 8'd4, 16'd4, 1'b0);
      chk("t3_ready_low", {31'd0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    chk("t3_ready_hs_cycle", {31'd0, in_ready}, 32'd0);
    step();
    chk("t3_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
    chk("t3_count_kept", {24'd0, out_count}, 32'd4);

    // Saturation: 17 x 16 = 272 clamps to 255
    for (int i = 0; i < 17; i++) send_beat(16'hFFFF, i == 16);
    in_valid = 1'b0;
    wait_out();
    chk_result("t4_sat", 8'd255, 16'd17, 1'b1);
    step();
    send_beat(16'h0003, 1'b1);
    in_valid = 1'b0;
    wait_out();
    chk_result("t4_after", 8'd2, 16'd1, 1'b0);
    step();

    // Reset mid-frame discards the partial frame
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    idle(1);
    rst_n = 1'b0;
    step();
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_count", {24'd0, out_count}, 32'd0);
    chk("t5_rst_beats", {16'd0, out_beats}, 32'd0);
    chk("t5_rst_ovf",   {31'd0, out_overflow}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_output", {31'd0, out_valid}, 32'd0);
    end
    send_beat(16'h0001, 1'b1);
    in_valid = 1'b0;
    wait_out();
    chk_result("t5_after", 8'd1, 16'd1, 1'b0);
    step();

    // Back-to-back frames with in_valid held high throughout
    send_beat(16'h00FF, 1'b1);
    in_vector = 16'h0F0F;
    in_last   = 1'b0;
    step();
    chk_result("t6_a", 8'd8, 16'd1, 1'b0);
    send_beat(16'h0F0F, 1'b0);
    send_beat(16'h0001, 1'b1);
    in_valid = 1'b0;
    wait_out();
    chk_result("t6_b", 8'd9, 16'd2, 1'b0);
    step();
    chk("t6_done", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/popcount_frame_accumulator.md
# popcount_frame_accumulator

Streaming stage that sits directly upstream of frame-level consumers and wraps the team's combinational popcount. It accepts a stream of `VECTOR_SIZE`-bit beats over a valid/ready handshake, computes each beat's population count, and accumulates the counts across a frame delimited by `in_last`. It then presents one per-frame total (count, beat count, overflow flag) on a valid/ready output held until accepted.

## Interface
- `VECTOR_SIZE`, 16: beat width; power of two, ≥2.
- `ACC_WIDTH`, 16: width of the frame total; must be ≥ `$clog2(VECTOR_SIZE)+1`.
- `BEAT_WIDTH`, 16: width of the frame beat counter.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_vector`  in  VECTOR_SIZE  beat data.
- `in_last`  in  1  beat is the final beat of its frame.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_count`  out  ACC_WIDTH  sum of popcounts over the frame, saturating.
- `out_beats`  out  BEAT_WIDTH  beats in the frame, saturating.
- `out_overflow`  out  1  `out_count` or `out_beats` saturated during this frame.

## Operation
- Per-beat popcount is combinational (recursive tree adder, width `PC_W = $clog2(VECTOR_SIZE)+1`), zero-extended to `ACC_WIDTH`.
- Pipeline register P: on input handshake, P loads `p_valid=1`, `p_cnt=popcount(in_vector)` and `p_last=in_last`. With no handshake, `p_valid=0`.
- Accumulators `acc` (ACC_WIDTH), `beats` (BEAT_WIDTH) and `ovf` (sticky) update when `p_valid=1`:
  - `acc_n = min(acc + p_cnt, 2^ACC_WIDTH-1)`.
  - `beats_n = min(beats+1, 2^BEAT_WIDTH-1)`.
  - `ovf_n = ovf | either clamp`.
  - Sums are computed one bit wider, then clamped.
- If `p_valid && !p_last`, store `acc_n`, `beats_n` and `ovf_n`.
- If `p_valid && p_last`:
  - Load `out_count=acc_n`, `out_beats=beats_n`, `out_overflow=ovf_n`, `out_valid=1`.
  - Clear `acc`, `beats` and `ovf` to 0.
  - Go to HOLD.
- FSM states:
  - ACCUM: collecting a frame.
  - HOLD: result pending.
  - HOLD→ACCUM on `out_valid && out_ready`, which also clears `out_valid`.
- `in_ready = rst_n && (state==ACCUM) && !(p_valid && p_last)`. This is combinational from registers and `rst_n` only, never from `in_valid` or `out_ready`.
- The output registers hold stable while `out_valid=1 && out_ready=0`. After acceptance they keep their last value with `out_valid=0`.
- Beats with `in_vector=0` are legal and count as beats.
- `in_valid` may drop at any cycle mid-frame. Gaps do not affect the totals.

## Timing
- Reset (`rst_n=0` at an edge): state=ACCUM; `p_valid`, `acc`, `beats`, `ovf`, `out_valid`, `out_count`, `out_beats` and `out_overflow` all go to 0. `in_ready=0` while `rst_n=0`.
- Reset mid-frame or during HOLD discards the partial frame or pending result. No output is produced for it.
- Latency: the last beat handshakes in cycle T, so `p_valid=1` in T+1 and `out_valid=1` in T+2.
- Throughput:
  - Within a frame: one beat per cycle.
  - Between frames: at least 3 cycles from last-beat handshake to the first beat of the next frame. `in_ready` is low in T+1 and through HOLD, including the cycle of the output handshake, and goes high the cycle after it.
- Single-beat frames are legal: one handshake with `in_last=1` gives a result with `out_beats=1`.
- Output handshake in the same cycle that `out_valid` rises is legal, giving a 1-cycle HOLD.

## Test plan
- Single frame, 1 beat `16'hFFFF`, `in_last=1`, `out_ready=1` → at T+2 `out_valid=1`, `out_count=16`, `out_beats=1`, `out_overflow=0`; `in_ready` high again at T+3.
- 3-beat frame `16'h000F`, `16'h00FF`, `16'hF0F0` (last), with a 2-cycle `in_valid` gap between beats 1 and 2 → `out_count=20`, `out_beats=3`.
- Backpressure: frame of `16'h0001` ×4, `out_ready=0` for 10 cycles → `out_count=4` and `out_beats=4` held stable, `in_ready=0` throughout; raise `out_ready` → `out_valid` falls next edge, `in_ready=1` the cycle after.
- Saturation with `ACC_WIDTH=8`: 17 beats of `16'hFFFF` (272) → `out_count=255`, `out_beats=17`, `out_overflow=1`; next 1-beat frame `16'h0003` → `out_count=2`, `out_overflow=0`.
- Reset mid-frame: 2 beats `16'hFFFF`, then `rst_n=0` for 1 cycle → all outputs 0, no `out_valid`; then 1-beat frame `16'h0001` → `out_count=1`, `out_beats=1`.
- Back-to-back frames with `in_valid` held high: frame A `16'h00FF` (last), frame B `16'h0F0F`+`16'h0001` (last) → results 8/1 then 9/2, in order, no beat lost or duplicated.
